serial_subtractor15: RTL and testbench
======================================

# serial_subtractor15

Bit-serial two's-complement subtractor. It computes A − B one bit per clock, LSB first, through a registered full-subtractor cell, and reports the borrow-out and the signed-overflow flag. It complements the ripple-carry adder/subtractor datapath: it gives the same 15-bit arithmetic contract in a small, area-minimal, multi-cycle form. Operands enter and results leave through valid/ready handshakes.

## Interface
- `WIDTH`, default 15: operand and result width in bits. Must be 2 or more.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand pair `a`/`b` is presented.
- `in_ready` output 1: block can accept operands. High only in IDLE.
- `a` input WIDTH: minuend, two's complement.
- `b` input WIDTH: subtrahend, two's complement.
- `out_valid` output 1: result fields are valid. High only in DONE.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: A − B modulo 2^WIDTH, or the saturated value (see Configuration).
- `borrow` output 1: unsigned borrow-out. High when A < B as unsigned values.
- `overflow` output 1: signed overflow of A − B.
- `busy` output 1: high in RUN.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: load `a`/`b` into shift registers, record the sign bits `a[WIDTH-1]` and `b[WIDTH-1]`, clear the borrow register and the bit counter, then go to RUN.
- **RUN**, one bit per cycle, using the current LSBs `a0`/`b0` and the borrow register `br`:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the MSB of the result register. Shift both operand registers right. Increment the counter.
- **RUN exit:** after the cycle that processes bit WIDTH−1 (counter == WIDTH−1), go to DONE and register the outputs:
  - `borrow` = br_next.
  - `overflow` = (sa != sb) & (d_msb != sa), where sa and sb are the recorded sign bits and d_msb is the final result bit.
- **DONE**
  - `out_valid` = 1.
  - `diff`, `borrow` and `overflow` are held stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
- The block has no pipelining: one operation is in flight at a time. `in_valid` is ignored outside IDLE.
- `diff`, `borrow` and `overflow` keep their last values in IDLE. Consumers sample them only while `out_valid` is high.
- `in_ready`, `out_valid` and `busy` are decoded from the state register only. No combinational path exists from any input to any output.
- All outputs are registered or state-decoded.

## Timing
- **Reset values:** state IDLE, `in_ready` 1, `out_valid` 0, `busy` 0, `diff` 0, `borrow` 0, `overflow` 0, counter 0, borrow register 0.
- **Latency:** with the accept handshake at edge T, RUN occupies edges T+1 through T+WIDTH, and `out_valid` is high from edge T+WIDTH (cycle T+WIDTH+1). For WIDTH = 15 this is 15 RUN cycles.
- **Output handshake:** when `out_ready` is high in the first DONE cycle, `out_valid` lasts one cycle and `in_ready` returns the next cycle. This gives a throughput of WIDTH+2 cycles per operation.
- **Backpressure:** `out_valid` and the result fields are held indefinitely while `out_ready` is low.
- **Reset mid-operation:** `rst` in any state returns the block to the reset values on that edge and drops the in-flight operation. `rst` has priority over both handshakes.
- **Edge cases:** a == b gives `diff` 0, `borrow` 0, `overflow` 0. b == 0 gives `diff` = a with no flags set. a = 0 with b = 100…0 overflows.

## Configuration
- Macro: `SERIAL_SUB_SATURATE_EN`.
- **Defined:** when `overflow` is 1, `diff` is clamped.
  - sa == 0 (positive overflow): `diff` = 0 followed by WIDTH−1 ones (0x3FFF for WIDTH = 15).
  - sa == 1 (negative overflow): `diff` = 1 followed by WIDTH−1 zeros (0x4000).
  - `borrow` and `overflow` are unaffected. Latency is unchanged because the clamp is applied on the RUN→DONE edge.
- **Undefined:** `diff` is always the wrapped modulo-2^WIDTH result and no clamp logic is present.

## Test plan
- a=0x0005, b=0x0003 -> `diff`=0x0002, `borrow`=0, `overflow`=0; `out_valid` rises exactly 15 cycles after the accept edge.
- a=0x0003, b=0x0005 -> `diff`=0x7FFE (−2), `borrow`=1, `overflow`=0.
- a=0x3FFF, b=0x7FFF (16383 − (−1)) -> `overflow`=1, `borrow`=1; `diff`=0x4000 without the macro, 0x3FFF with it.
- a=0x4000, b=0x0001 (−16384 − 1) -> `overflow`=1, `borrow`=0; `diff`=0x3FFF without the macro, 0x4000 with it.
- Hold `out_ready` low for 5 DONE cycles and pulse `in_valid` with new operands during RUN and DONE -> result fields stable, `in_ready`=0 throughout, the new operands are not accepted, and the next accept happens only after the output handshake.
- Assert `rst` for 1 cycle on the 7th RUN cycle of a=0x1234, b=0x0FFF -> next cycle state IDLE, `in_ready`=1, all other outputs 0; the next operation a=0x0010, b=0x0001 gives `diff`=0x000F with no flags.

Source files
------------

// File: rtl/serial_subtractor15.sv
// Bit-serial two's-complement subtractor: A - B, LSB first, one bit per clock.
// Optional result clamping on signed overflow when SERIAL_SUB_SATURATE_EN is defined.
module serial_subtractor15 #(
   parameter int unsigned WIDTH = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow,
   output logic             busy
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
`ifdef SERIAL_SUB_SATURATE_EN
   localparam logic [WIDTH-1:0] NEG_SAT = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] POS_SAT = {1'b0, {(WIDTH-1){1'b1}}};
`endif

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             sa;
   logic             sb;

   logic             d_bit;
   logic             br_next;
   logic             ovf_next;
   logic [WIDTH-1:0] res_final;

   // Full-subtractor cell; result bits refill sh_a from the top as the minuend drains out.
   always_comb begin
      d_bit     = sh_a[0] ^ sh_b[0] ^ br;
      br_next   = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
      ovf_next  = (sa != sb) & (d_bit != sa);
      res_final = {d_bit, sh_a[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         diff      <= '0;
         borrow    <= 1'b0;
         overflow  <= 1'b0;
         sh_a      <= '0;
         sh_b      <= '0;
         cnt       <= '0;
         br        <= 1'b0;
         sa        <= 1'b0;
         sb        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sh_a     <= a;
                  sh_b     <= b;
                  sa       <= a[WIDTH-1];
                  sb       <= b[WIDTH-1];
                  br       <= 1'b0;
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               sh_a <= res_final;
               sh_b <= {1'b0, sh_b[WIDTH-1:1]};
               br   <= br_next;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST_BIT) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  borrow    <= br_next;
                  overflow  <= ovf_next;
`ifdef SERIAL_SUB_SATURATE_EN
                  if (ovf_next) diff <= sa ? NEG_SAT : POS_SAT;
                  else          diff <= res_final;
`else
                  diff      <= res_final;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor15.sv
// Directed self-checking bench for serial_subtractor15 (WIDTH = 15).
module tb_serial_subtractor15;

   localparam int unsigned W = 15;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         overflow;
   logic         busy;

   int errors = 0;
   int checks = 0;

   serial_subtractor15 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow(borrow), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, borrow, overflow} !== 5'b10000 || diff !== 15'h0) begin
         errors++;
         $display("FAIL reset: rdy/vld/busy/bor/ovf=%b diff=%h, required 10000 diff=0000",
                  {in_ready, out_valid, busy, borrow, overflow}, diff);
      end
   endtask

   // Presents operands in IDLE, measures latency and checks the result, then completes the handshake.
   task automatic test_arith(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                             input logic [W-1:0] ed, input logic eb, input logic eo);
      int n;
      a = va; b = vb; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s run_flags: busy=%b in_ready=%b, required busy=1 in_ready=0", name, busy, in_ready);
      end
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL %s latency: %0d cycles, required 15", name, n);
      end
      checks++;
      if (diff !== ed || borrow !== eb || overflow !== eo) begin
         errors++;
         $display("FAIL %s result: diff=%h bor=%b ovf=%b, required diff=%h bor=%b ovf=%b",
                  name, diff, borrow, overflow, ed, eb, eo);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s handshake: in_ready=%b out_valid=%b, required 1 0", name, in_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      a = 15'h0005; b = 15'h0003; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         if (n == 3) begin
            a = 15'h7FFF; b = 15'h0000; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL bp latency: %0d cycles, required 15", n);
      end
      a = 15'h0007; b = 15'h0002; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 15'h0002 || borrow !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp hold%0d: vld=%b rdy=%b diff=%h bor=%b ovf=%b, required 1 0 0002 0 0",
                     i, out_valid, in_ready, diff, borrow, overflow);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp after_handshake: rdy=%b busy=%b vld=%b, required 1 0 0", in_ready, busy, out_valid);
      end
      // in_valid is still high, so this edge is the next accept
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 15 || diff !== 15'h0005 || borrow !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL bp next_op: lat=%0d diff=%h bor=%b ovf=%b, required 15 0005 0 0", n, diff, borrow, overflow);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      a = 15'h1234; b = 15'h0FFF; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy, borrow, overflow} !== 5'b10000 || diff !== 15'h0) begin
         errors++;
         $display("FAIL mid_reset: rdy/vld/busy/bor/ovf=%b diff=%h, required 10000 diff=0000",
                  {in_ready, out_valid, busy, borrow, overflow}, diff);
      end
      test_arith("after_reset", 15'h0010, 15'h0001, 15'h000F, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_arith("basic", 15'h0005, 15'h0003, 15'h0002, 1'b0, 1'b0);
      test_arith("neg_result", 15'h0003, 15'h0005, 15'h7FFE, 1'b1, 1'b0);
`ifdef SERIAL_SUB_SATURATE_EN
      test_arith("pos_ovf", 15'h3FFF, 15'h7FFF, 15'h3FFF, 1'b1, 1'b1);
      test_arith("neg_ovf", 15'h4000, 15'h0001, 15'h4000, 1'b0, 1'b1);
      test_arith("zero_minus_min", 15'h0000, 15'h4000, 15'h3FFF, 1'b1, 1'b1);
`else
      test_arith("pos_ovf", 15'h3FFF, 15'h7FFF, 15'h4000, 1'b1, 1'b1);
      test_arith("neg_ovf", 15'h4000, 15'h0001, 15'h3FFF, 1'b0, 1'b1);
      test_arith("zero_minus_min", 15'h0000, 15'h4000, 15'h4000, 1'b1, 1'b1);
`endif
      test_arith("a_eq_b", 15'h2AAA, 15'h2AAA, 15'h0000, 1'b0, 1'b0);
      test_arith("b_zero", 15'h5555, 15'h0000, 15'h5555, 1'b0, 1'b0);
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
